rcc_cfg_regs: RTL and testbench

- AHB-Lite slave register bank directly upstream of the reset/clock controller.
- Produces the divider ratios (PCLK_PCLKG_DIV, TIMCLK_DIV, WDOGCLK_DIV) and the APB_ACTIVE gate enable that the controller consumes.
- Software writes staged ratios; a COMMIT transfers them atomically to the outputs, followed by a settle window.
- APB_ACTIVE is generated from bridge activity with a programmable idle timeout, or forced by software.

---
 rtl/rcc_cfg_regs.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_rcc_cfg_regs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_cfg_regs.sv
// rcc_cfg_regs
// ------------------------------------------------------------------------
// AHB-Lite register bank feeding the reset/clock controller. Software
// stages three clock-divider ratios and then commits them all together to
// the active outputs. A settle window follows each commit and reports BUSY.
// The bank also drives APB_ACTIVE, the PCLKG gate enable. It follows bridge
// activity with a programmable idle timeout, or software can force it on.
//
// Register map (word index = HADDR[4:2], HADDR[7:5] must be zero):
//   0x00 PDIV_STG   staged PCLK/PCLKG ratio (low SCALE1 bits)
//   0x04 TDIV_STG   staged TIMCLK ratio     (low SCALE2 bits)
//   0x08 WDIV_STG   staged WDOGCLK ratio    (low SCALE3 bits)
//   0x0C CTRL       [0] COMMIT (write-1, reads 0) [1] APB_AUTO [2] APB_FORCE
//   0x10 STATUS     [0] BUSY [1] APB_ACTIVE [2] COMMIT_DROP (W1C)
//   0x14 IDLE_TMO   idle timeout for APB_ACTIVE in auto mode
//   other          read 0, writes ignored, response always OKAY
//
// Commit FSM:
//   state     | meaning
//   ST_IDLE   | ratios stable, a COMMIT write copies staged -> active
//   ST_SETTLE | settle window after a commit; BUSY=1, APB_ACTIVE held 0,
//             | further COMMIT writes are dropped and flagged
//
// Ports:
//   HCLK, RST                     clock, asynchronous active-high reset
//   HSEL..HREADY                  AHB-Lite slave inputs
//   HRDATA, HREADYOUT, HRESP      AHB-Lite slave outputs (zero wait, OKAY)
//   APB_REQ                       bridge has an APB transfer pending
//   PCLK_PCLKG_DIV, TIMCLK_DIV,
//   WDOGCLK_DIV                   active divider ratios
//   APB_ACTIVE                    PCLKG gate enable (registered)
// ------------------------------------------------------------------------
module rcc_cfg_regs #(
    parameter int SCALE1        = 8,
    parameter int SCALE2        = 8,
    parameter int SCALE3        = 8,
    parameter int DEF_DIV       = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int TMO_W         = 8
) (
    input  logic              HCLK,
    input  logic              RST,
    input  logic              HSEL,
    input  logic [7:0]        HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    input  logic              APB_REQ,
    output logic [SCALE1-1:0] PCLK_PCLKG_DIV,
    output logic [SCALE2-1:0] TIMCLK_DIV,
    output logic [SCALE3-1:0] WDOGCLK_DIV,
    output logic              APB_ACTIVE
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    localparam logic [2:0] IDX_PDIV   = 3'd0;
    localparam logic [2:0] IDX_TDIV   = 3'd1;
    localparam logic [2:0] IDX_WDIV   = 3'd2;
    localparam logic [2:0] IDX_CTRL   = 3'd3;
    localparam logic [2:0] IDX_STATUS = 3'd4;
    localparam logic [2:0] IDX_TMO    = 3'd5;

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } state_t;

    // Bus data-phase tracking
    logic             dp_valid_q, dp_valid_d;
    logic             dp_write_q, dp_write_d;
    logic [5:0]       dp_addr_q,  dp_addr_d;

    // Configuration / status
    logic [SCALE1-1:0] pdiv_stg_q, pdiv_stg_d;
    logic [SCALE2-1:0] tdiv_stg_q, tdiv_stg_d;
    logic [SCALE3-1:0] wdiv_stg_q, wdiv_stg_d;
    logic [SCALE1-1:0] pdiv_act_q, pdiv_act_d;
    logic [SCALE2-1:0] tdiv_act_q, tdiv_act_d;
    logic [SCALE3-1:0] wdiv_act_q, wdiv_act_d;
    logic              ctrl_auto_q,  ctrl_auto_d;
    logic              ctrl_force_q, ctrl_force_d;
    logic [TMO_W-1:0]  idle_tmo_q,   idle_tmo_d;
    logic              commit_drop_q, commit_drop_d;

    // Commit FSM and APB activity tracking
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TMO_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic              apb_active_q, apb_active_d;

    // Decode helpers
    logic              addr_accept;
    logic              wr_en;
    logic              rd_en;
    logic              in_map;
    logic [2:0]        reg_idx;
    logic              wr_ctrl;
    logic              wr_status;
    logic              commit_req;
    logic              auto_active;
    logic              busy;
    logic [31:0]       rdata;

    // Inputs that carry no information for this slave (32-bit only,
    // word-aligned, SEQ/NONSEQ treated alike).
    logic              unused_inputs;
    assign unused_inputs = ^{HSIZE, HADDR[1:0], HTRANS[0], HWDATA};

    // --------------------------------------------------------------------
    // AHB address/data phase
    // --------------------------------------------------------------------
    assign addr_accept = HSEL & HTRANS[1] & HREADY;

    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        if (HREADY) begin
            dp_valid_d = addr_accept;
            if (addr_accept) begin
                dp_write_d = HWRITE;
                dp_addr_d  = HADDR[7:2];
            end
        end
    end

    assign in_map  = (dp_addr_q[5:3] == 3'b000);
    assign reg_idx = dp_addr_q[2:0];
    // A write lands on the edge that ends its data phase.
    assign wr_en   = dp_valid_q & dp_write_q & HREADY & in_map;
    assign rd_en   = dp_valid_q & ~dp_write_q & in_map;

    assign wr_ctrl    = wr_en & (reg_idx == IDX_CTRL);
    assign wr_status  = wr_en & (reg_idx == IDX_STATUS);
    assign commit_req = wr_ctrl & HWDATA[0];

    // --------------------------------------------------------------------
    // Software-visible registers
    // --------------------------------------------------------------------
    always_comb begin
        pdiv_stg_d   = pdiv_stg_q;
        tdiv_stg_d   = tdiv_stg_q;
        wdiv_stg_d   = wdiv_stg_q;
        ctrl_auto_d  = ctrl_auto_q;
        ctrl_force_d = ctrl_force_q;
        idle_tmo_d   = idle_tmo_q;
        if (wr_en) begin
            case (reg_idx)
                IDX_PDIV: pdiv_stg_d = HWDATA[SCALE1-1:0];
                IDX_TDIV: tdiv_stg_d = HWDATA[SCALE2-1:0];
                IDX_WDIV: wdiv_stg_d = HWDATA[SCALE3-1:0];
                IDX_CTRL: begin
                    ctrl_auto_d  = HWDATA[1];
                    ctrl_force_d = HWDATA[2];
                end
                IDX_TMO:  idle_tmo_d = HWDATA[TMO_W-1:0];
                default:  ;
            endcase
        end
    end

    // --------------------------------------------------------------------
    // Commit FSM
    // --------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        pdiv_act_d    = pdiv_act_q;
        tdiv_act_d    = tdiv_act_q;
        wdiv_act_d    = wdiv_act_q;
        commit_drop_d = commit_drop_q;

        if (wr_status && HWDATA[2]) begin
            commit_drop_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (commit_req) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SETTLE_LOAD;
                    // A zero ratio would stall the divider; coerce to 1.
                    pdiv_act_d = (pdiv_stg_q == '0) ? SCALE1'(1) : pdiv_stg_q;
                    tdiv_act_d = (tdiv_stg_q == '0) ? SCALE2'(1) : tdiv_stg_q;
                    wdiv_act_d = (wdiv_stg_q == '0) ? SCALE3'(1) : wdiv_stg_q;
                end
            end
            ST_SETTLE: begin
                if (commit_req) begin
                    commit_drop_d = 1'b1;
                end
                if (settle_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_SETTLE);

    // --------------------------------------------------------------------
    // APB_ACTIVE generation
    // --------------------------------------------------------------------
    // The idle counter sits at IDLE_TMO until a countdown is in progress,
    // so a re-asserted APB_REQ always restarts the full timeout.
    always_comb begin
        auto_active = 1'b0;
        idle_cnt_d  = idle_tmo_q;
        if (APB_REQ) begin
            auto_active = 1'b1;
        end else if (apb_active_q && (idle_cnt_q != '0)) begin
            auto_active = 1'b1;
            idle_cnt_d  = idle_cnt_q - 1'b1;
        end
    end

    always_comb begin
        apb_active_d = 1'b0;
        if (state_d == ST_SETTLE) begin
            apb_active_d = 1'b0;
        end else if (ctrl_force_q) begin
            apb_active_d = 1'b1;
        end else if (ctrl_auto_q) begin
            apb_active_d = auto_active;
        end
    end

    // --------------------------------------------------------------------
    // Read mux (combinational from the registered data-phase address)
    // --------------------------------------------------------------------
    always_comb begin
        rdata = 32'h0;
        if (rd_en) begin
            case (reg_idx)
                IDX_PDIV:   rdata = 32'(pdiv_stg_q);
                IDX_TDIV:   rdata = 32'(tdiv_stg_q);
                IDX_WDIV:   rdata = 32'(wdiv_stg_q);
                IDX_CTRL:   rdata = {29'h0, ctrl_force_q, ctrl_auto_q, 1'b0};
                IDX_STATUS: rdata = {29'h0, commit_drop_q, apb_active_q, busy};
                IDX_TMO:    rdata = 32'(idle_tmo_q);
                default:    rdata = 32'h0;
            endcase
        end
    end

    // --------------------------------------------------------------------
    // State registers
    // --------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge RST) begin
        if (RST) begin
            dp_valid_q    <= 1'b0;
            dp_write_q    <= 1'b0;
            dp_addr_q     <= '0;
            pdiv_stg_q    <= SCALE1'(DEF_DIV);
            tdiv_stg_q    <= SCALE2'(DEF_DIV);
            wdiv_stg_q    <= SCALE3'(DEF_DIV);
            pdiv_act_q    <= SCALE1'(DEF_DIV);
            tdiv_act_q    <= SCALE2'(DEF_DIV);
            wdiv_act_q    <= SCALE3'(DEF_DIV);
            ctrl_auto_q   <= 1'b1;
            ctrl_force_q  <= 1'b0;
            idle_tmo_q    <= '0;
            commit_drop_q <= 1'b0;
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            idle_cnt_q    <= '0;
            apb_active_q  <= 1'b0;
        end else begin
            dp_valid_q    <= dp_valid_d;
            dp_write_q    <= dp_write_d;
            dp_addr_q     <= dp_addr_d;
            pdiv_stg_q    <= pdiv_stg_d;
            tdiv_stg_q    <= tdiv_stg_d;
            wdiv_stg_q    <= wdiv_stg_d;
            pdiv_act_q    <= pdiv_act_d;
            tdiv_act_q    <= tdiv_act_d;
            wdiv_act_q    <= wdiv_act_d;
            ctrl_auto_q   <= ctrl_auto_d;
            ctrl_force_q  <= ctrl_force_d;
            idle_tmo_q    <= idle_tmo_d;
            commit_drop_q <= commit_drop_d;
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            apb_active_q  <= apb_active_d;
        end
    end

    // --------------------------------------------------------------------
    // Outputs
    // --------------------------------------------------------------------
    assign HRDATA         = rdata;
    assign HREADYOUT      = 1'b1;
    assign HRESP          = 1'b0;
    assign PCLK_PCLKG_DIV = pdiv_act_q;
    assign TIMCLK_DIV     = tdiv_act_q;
    assign WDOGCLK_DIV    = wdiv_act_q;
    assign APB_ACTIVE     = apb_active_q;

endmodule

// File: tb/tb_rcc_cfg_regs.sv
// Directed bench for rcc_cfg_regs: register access, atomic commit with
// settle window, dropped commits, APB_ACTIVE idle timeout, forced gating,
// asynchronous reset mid-settle and bus corner cases.
module tb_rcc_cfg_regs;

    logic        HCLK;
    logic        RST;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        APB_REQ;
    logic [7:0]  PCLK_PCLKG_DIV;
    logic [7:0]  TIMCLK_DIV;
    logic [7:0]  WDOGCLK_DIV;
    logic        APB_ACTIVE;

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] rv;
    int          cnt;

    rcc_cfg_regs dut (
        .HCLK           (HCLK),
        .RST            (RST),
        .HSEL           (HSEL),
        .HADDR          (HADDR),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HSIZE          (HSIZE),
        .HWDATA         (HWDATA),
        .HREADY         (HREADY),
        .HRDATA         (HRDATA),
        .HREADYOUT      (HREADYOUT),
        .HRESP          (HRESP),
        .APB_REQ        (APB_REQ),
        .PCLK_PCLKG_DIV (PCLK_PCLKG_DIV),
        .TIMCLK_DIV     (TIMCLK_DIV),
        .WDOGCLK_DIV    (WDOGCLK_DIV),
        .APB_ACTIVE     (APB_ACTIVE)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic ap(input logic [7:0] a, input logic w);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = w;
        HADDR  = a;
        HSIZE  = 3'b010;
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        ap(a, 1'b1);
        tick();
        HWDATA = d;
        bus_idle();
        tick();
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        ap(a, 1'b0);
        tick();
        bus_idle();
        d = HRDATA;
        tick();
    endtask

    initial begin
        RST = 1'b1; HSEL = 1'b0; HADDR = 8'h0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HWDATA = 32'h0; HREADY = 1'b1; APB_REQ = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;

        // Reset state
        chk("rst_pdiv",   32'(PCLK_PCLKG_DIV), 32'd2);
        chk("rst_tdiv",   32'(TIMCLK_DIV),     32'd2);
        chk("rst_wdiv",   32'(WDOGCLK_DIV),    32'd2);
        chk("rst_apb",    32'(APB_ACTIVE),     32'd0);
        chk("rst_hrdata", HRDATA,              32'd0);
        RST = 1'b0;
        tick();
        rd(8'h0C, rv); chk("rst_ctrl",   rv, 32'h2);
        rd(8'h10, rv); chk("rst_status", rv, 32'h0);

        // Stage, truncate, commit with zero coercion; BUSY window length
        wr(8'h00, 32'd5);
        wr(8'h04, 32'd0);
        wr(8'h08, 32'h1FF);
        rd(8'h08, rv); chk("wdiv_stg_trunc", rv, 32'hFF);
        rd(8'h04, rv); chk("tdiv_stg_zero",  rv, 32'h0);
        chk("pdiv_staged_not_active", 32'(PCLK_PCLKG_DIV), 32'd2);
        ap(8'h0C, 1'b1);
        tick();
        HWDATA = 32'h3;
        ap(8'h10, 1'b0);
        chk("pdiv_in_commit_dphase", 32'(PCLK_PCLKG_DIV), 32'd2);
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 0) begin
                chk("status_settle_start", HRDATA, 32'h1);
                chk("commit_pdiv", 32'(PCLK_PCLKG_DIV), 32'd5);
                chk("commit_tdiv", 32'(TIMCLK_DIV),     32'd1);
                chk("commit_wdiv", 32'(WDOGCLK_DIV),    32'hFF);
            end
            if (HRDATA[0]) cnt++;
        end
        bus_idle();
        tick();
        chk("busy_cycles", 32'(cnt), 32'd16);

        // Commit during settle is dropped and flagged
        wr(8'h00, 32'd7);
        wr(8'h0C, 32'h3);
        chk("commit2_pdiv", 32'(PCLK_PCLKG_DIV), 32'd7);
        wr(8'h00, 32'd9);
        wr(8'h0C, 32'h3);
        chk("drop_pdiv_unchanged", 32'(PCLK_PCLKG_DIV), 32'd7);
        repeat (20) tick();
        rd(8'h10, rv); chk("status_drop", rv, 32'h4);
        chk("drop_pdiv_after_settle", 32'(PCLK_PCLKG_DIV), 32'd7);
        wr(8'h10, 32'h4);
        rd(8'h10, rv); chk("status_drop_cleared", rv, 32'h0);
        rd(8'h00, rv); chk("stg_write_in_settle", rv, 32'd9);

        // Auto mode, IDLE_TMO = 3
        wr(8'h14, 32'd3);
        APB_REQ = 1'b1;
        chk("apb_pre_rise", 32'(APB_ACTIVE), 32'd0);
        tick();
        chk("apb_rise", 32'(APB_ACTIVE), 32'd1);
        tick(); tick(); tick();
        APB_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("apb_countdown_hold", 32'(APB_ACTIVE), 32'd1);
        end
        tick();
        chk("apb_timeout_drop", 32'(APB_ACTIVE), 32'd0);

        // Re-pulse when the countdown reaches 1
        APB_REQ = 1'b1;
        tick();
        chk("apb_pulse_rise", 32'(APB_ACTIVE), 32'd1);
        APB_REQ = 1'b0;
        tick(); tick();
        APB_REQ = 1'b1;
        tick();
        APB_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("apb_repulse_hold", 32'(APB_ACTIVE), 32'd1);
        end
        tick();
        chk("apb_repulse_drop", 32'(APB_ACTIVE), 32'd0);

        // IDLE_TMO = 0 drops one cycle after APB_REQ goes low
        wr(8'h14, 32'd0);
        APB_REQ = 1'b1;
        tick();
        chk("apb_tmo0_rise", 32'(APB_ACTIVE), 32'd1);
        APB_REQ = 1'b0;
        tick();
        chk("apb_tmo0_drop", 32'(APB_ACTIVE), 32'd0);

        // AUTO=0, FORCE=0 ignores bridge activity
        wr(8'h0C, 32'h0);
        APB_REQ = 1'b1;
        tick(); tick();
        chk("apb_auto_off", 32'(APB_ACTIVE), 32'd0);
        APB_REQ = 1'b0;

        // FORCE, then FORCE with COMMIT: gated off for the whole settle
        wr(8'h0C, 32'h4);
        tick();
        chk("apb_force_on", 32'(APB_ACTIVE), 32'd1);
        wr(8'h0C, 32'h5);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (APB_ACTIVE == 1'b0) cnt++;
            tick();
        end
        chk("apb_low_in_settle", 32'(cnt), 32'd16);
        chk("apb_force_after_settle", 32'(APB_ACTIVE), 32'd1);
        chk("commit3_pdiv", 32'(PCLK_PCLKG_DIV), 32'd9);
        rd(8'h10, rv); chk("status_force", rv, 32'h2);

        // Asynchronous reset in the middle of a settle window
        wr(8'h00, 32'h33);
        wr(8'h0C, 32'h5);
        repeat (5) tick();
        chk("pdiv_pre_reset", 32'(PCLK_PCLKG_DIV), 32'h33);
        RST = 1'b1;
        #2;
        chk("arst_pdiv",   32'(PCLK_PCLKG_DIV), 32'd2);
        chk("arst_tdiv",   32'(TIMCLK_DIV),     32'd2);
        chk("arst_wdiv",   32'(WDOGCLK_DIV),    32'd2);
        chk("arst_apb",    32'(APB_ACTIVE),     32'd0);
        chk("arst_hrdata", HRDATA,              32'd0);
        tick();
        RST = 1'b0;
        rd(8'h10, rv); chk("arst_status", rv, 32'h0);
        rd(8'h0C, rv); chk("arst_ctrl",   rv, 32'h2);
        rd(8'h00, rv); chk("arst_pdiv_stg", rv, 32'd2);

        // Back-to-back write then read, unmapped read
        ap(8'h00, 1'b1);
        tick();
        HWDATA = 32'hA5;
        ap(8'h00, 1'b0);
        chk("hrdata_zero_in_wr_dphase", HRDATA, 32'h0);
        tick();
        chk("b2b_read_new", HRDATA, 32'hA5);
        ap(8'h1C, 1'b0);
        tick();
        chk("rd_1c_zero",   HRDATA,            32'h0);
        chk("rd_1c_hresp",  32'(HRESP),        32'd0);
        chk("rd_1c_hready", 32'(HREADYOUT),    32'd1);
        bus_idle();
        tick();

        // HTRANS=BUSY does not start a transfer
        HSEL = 1'b1; HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 8'h00;
        tick();
        HWDATA = 32'h11;
        bus_idle();
        tick();
        rd(8'h00, rv); chk("htrans_busy_ignored", rv, 32'hA5);

        // HADDR[7:5] != 0 must not alias onto the map
        wr(8'h20, 32'h77);
        rd(8'h00, rv); chk("alias_write_ignored", rv, 32'hA5);
        rd(8'h20, rv); chk("alias_read_zero",     rv, 32'h0);

        // Upper bits of a staged register read 0
        wr(8'h00, 32'hFFFF_FFFF);
        rd(8'h00, rv); chk("pdiv_stg_upper_zero", rv, 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
